rr_burst_arbiter: RTL and testbench
===================================

Name: rr_burst_arbiter

Overview:
- Sequencing arbiter that shares the single GPU interconnect bus between shader-core masters.
- Grants one master at a time in round-robin order and holds the grant for a whole burst. Release happens on last beat, burst cap, requester withdrawal, or slave-stall timeout.
- Its one-hot grant drives the interconnect's master mux and slave fanout.
- Replaces combinational per-cycle arbitration with transaction-level ownership.

Parameters:
- NUM_MASTERS, 4: number of requesters, ≥2.
- MAX_BURST, 8: maximum accepted beats per grant, ≥1.
- TIMEOUT, 255: maximum consecutive owned cycles without an ack before forced release, ≥1.

Ports:
- clk  input  1  clock
- rst  input  1  synchronous active-high reset
- i_req  input  NUM_MASTERS  per-master bus request, level
- i_last  input  NUM_MASTERS  per-master: current beat is the final beat of the burst
- i_slave_ack  input  1  slave accepted the current beat this cycle
- o_grant  output  NUM_MASTERS  one-hot grant, all-zero when idle
- o_grant_idx  output  $clog2(NUM_MASTERS)  index of owner, 0 when idle
- o_busy  output  1  grant held (state OWN)
- o_timeout  output  1  one-cycle pulse when the grant is revoked by timeout

Behaviour:
- One clock domain: clk. Reset is synchronous and active-high (rst). All state updates on the rising clk edge.
- Reset values:
  - state=IDLE, o_grant=0, o_grant_idx=0, o_busy=0, o_timeout=0.
  - rr_ptr=0, so master 0 has first priority.
  - beat_cnt=0, idle_cnt=0.
- Reset mid-burst: grant drops at that edge. No timeout pulse. Pointer returns to 0.
- States: IDLE, OWN. All outputs are registered.
- IDLE:
  - If |i_req, select the first requesting index searching rr_ptr, rr_ptr+1, … with wrap mod NUM_MASTERS.
  - Register o_grant/o_grant_idx, set o_busy=1, clear beat_cnt and idle_cnt, go to OWN.
  - Latency: request seen at edge N, grant visible after edge N.
  - i_slave_ack is ignored in IDLE.
- OWN, evaluated each cycle for owner k:
  - ack = i_slave_ack. On ack: beat_cnt++, idle_cnt=0. Otherwise idle_cnt++.
  - Release conditions:
    - (a) ack && i_last[k]
    - (b) ack && beat_cnt+1 == MAX_BURST
    - (c) !i_req[k] (withdrawal; a same-cycle ack still counts)
    - (d) !ack && idle_cnt == TIMEOUT-1, i.e. the TIMEOUT-th consecutive ack-less owned cycle
  - On release: go to IDLE, clear o_grant/o_busy/o_grant_idx, set rr_ptr=(k+1) mod NUM_MASTERS.
  - Condition (d) also asserts o_timeout for exactly the following cycle.
  - Priority: an ack in a cycle always suppresses a timeout. Conditions (a), (b), (c) and (d) may coincide; release happens once and the pointer update is identical.
- Handover gap: exactly one all-zero grant cycle between consecutive grants (the IDLE arbitration cycle). Never two bits set in o_grant.
- A sole continuous requester is re-granted after each one-cycle gap. The pointer wraps naturally.
- Requests from non-owners during OWN are ignored until IDLE.
- Counter widths:
  - beat_cnt: $clog2(MAX_BURST+1).
  - idle_cnt: $clog2(TIMEOUT+1).
  - Neither counter ever wraps, because release occurs first.
- i_last/i_req from non-owners have no effect in OWN.

Test Plan (NUM_MASTERS=4, MAX_BURST=4, TIMEOUT=8):
- Reset, then i_req=4'b1010 held, ack every cycle, i_last at beat 2 → grant 4'b0010 for 2 cycles, 1 idle cycle, then 4'b1000 for 2 cycles, then 4'b0010 again; o_grant_idx 1,3,1.
- i_req=4'b0001 held, ack every cycle, i_last never → grant holds exactly 4 ack cycles (MAX_BURST), 1-cycle gap, re-grant to master 0.
- Master 2 granted, i_slave_ack=0 for 8 cycles → release after 8th owned cycle, o_timeout=1 for one cycle, next grant search starts at 3.
- Master 1 owns, idle_cnt=7, ack and i_last arrive that cycle → normal release, o_timeout stays 0, beat_cnt=1 logged.
- Master 0 owns, deasserts i_req mid-burst, with master 3 requesting → release next edge, grant 4'b1000 after one gap cycle.
- rst=1 asserted while master 2 owns with beat_cnt=3 → next cycle all outputs 0. After release with i_req=4'b0101, master 0 granted first.

Source files
------------

// File: rtl/rr_burst_arbiter.sv
// Round-robin bus arbiter that grants one master for a whole burst and releases on
// last beat, burst cap, request withdrawal or slave-stall timeout.
module rr_burst_arbiter #(
  parameter int NUM_MASTERS = 4,
  parameter int MAX_BURST   = 8,
  parameter int TIMEOUT     = 255
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_MASTERS-1:0]         i_req,
  input  logic [NUM_MASTERS-1:0]         i_last,
  input  logic                           i_slave_ack,
  output logic [NUM_MASTERS-1:0]         o_grant,
  output logic [$clog2(NUM_MASTERS)-1:0] o_grant_idx,
  output logic                           o_busy,
  output logic                           o_timeout
);

  localparam int IW = $clog2(NUM_MASTERS);
  localparam int BW = $clog2(MAX_BURST + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [BW-1:0] BEAT_LAST = BW'(MAX_BURST - 1);
  localparam logic [TW-1:0] IDLE_LAST = TW'(TIMEOUT - 1);

  typedef enum logic {ST_IDLE, ST_OWN} state_t;

  state_t                 state_q, state_d;
  logic [NUM_MASTERS-1:0] grant_q, grant_d;
  logic [IW-1:0]          idx_q, idx_d;
  logic [IW-1:0]          ptr_q, ptr_d;
  logic [BW-1:0]          beat_q, beat_d;
  logic [TW-1:0]          idle_q, idle_d;
  logic                   timeout_q, timeout_d;

  logic [IW-1:0] cand;
  logic [IW-1:0] sel;
  logic          found;
  logic          rel_to;
  logic          rel;

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    idx_d     = idx_q;
    ptr_d     = ptr_q;
    beat_d    = beat_q;
    idle_d    = idle_q;
    timeout_d = 1'b0;
    cand      = '0;
    sel       = '0;
    found     = 1'b0;
    rel_to    = 1'b0;
    rel       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // Search starts at the pointer and wraps, so the first hit is the fairest pick.
        for (int i = 0; i < NUM_MASTERS; i++) begin
          cand = IW'((int'(ptr_q) + i) % NUM_MASTERS);
          if (!found && i_req[cand]) begin
            found = 1'b1;
            sel   = cand;
          end
        end
        if (found) begin
          state_d      = ST_OWN;
          grant_d      = '0;
          grant_d[sel] = 1'b1;
          idx_d        = sel;
          beat_d       = '0;
          idle_d       = '0;
        end
      end
      ST_OWN: begin
        if (i_slave_ack) begin
          beat_d = beat_q + 1'b1;
          idle_d = '0;
        end else begin
          idle_d = idle_q + 1'b1;
        end
        // An ack in the same cycle always wins over the stall timeout.
        rel_to = !i_slave_ack && (idle_q == IDLE_LAST);
        rel    = (i_slave_ack && (i_last[idx_q] || (beat_q == BEAT_LAST)))
                 || !i_req[idx_q] || rel_to;
        if (rel) begin
          state_d   = ST_IDLE;
          grant_d   = '0;
          idx_d     = '0;
          ptr_d     = IW'((int'(idx_q) + 1) % NUM_MASTERS);
          timeout_d = rel_to;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      grant_q   <= '0;
      idx_q     <= '0;
      ptr_q     <= '0;
      beat_q    <= '0;
      idle_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      idx_q     <= idx_d;
      ptr_q     <= ptr_d;
      beat_q    <= beat_d;
      idle_q    <= idle_d;
      timeout_q <= timeout_d;
    end
  end

  assign o_grant     = grant_q;
  assign o_grant_idx = idx_q;
  assign o_busy      = (state_q == ST_OWN);
  assign o_timeout   = timeout_q;

endmodule

// File: tb/tb_rr_burst_arbiter.sv
// Directed bench for rr_burst_arbiter: each row drives inputs for one cycle and
// lists the outputs expected right after the following rising edge.
module tb_rr_burst_arbiter;

  localparam int N = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [N-1:0] i_req = '0;
  logic [N-1:0] i_last = '0;
  logic         i_slave_ack = 1'b0;
  logic [N-1:0] o_grant;
  logic [1:0]   o_grant_idx;
  logic         o_busy;
  logic         o_timeout;

  int n_cmp  = 0;
  int n_fail = 0;

  typedef struct packed {
    logic       rst;
    logic [3:0] req;
    logic [3:0] last;
    logic       ack;
    logic [3:0] g;
    logic [1:0] idx;
    logic       busy;
    logic       to;
  } vec_t;

  rr_burst_arbiter #(.NUM_MASTERS(4), .MAX_BURST(4), .TIMEOUT(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .i_req       (i_req),
    .i_last      (i_last),
    .i_slave_ack (i_slave_ack),
    .o_grant     (o_grant),
    .o_grant_idx (o_grant_idx),
    .o_busy      (o_busy),
    .o_timeout   (o_timeout)
  );

  always #5 clk = ~clk;

  // Reset, then 1010 held with last on beat 2: grants 1,3,1 with one-cycle gaps.
  task automatic test_reset_rr();
    vec_t v [8];
    v = '{
      '{1'b1, 4'b0000, 4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b0},
      '{1'b0, 4'b1010, 4'b0000, 1'b1, 4'b0010, 2'd1, 1'b1, 1'b0},
      '{1'b0, 4'b1010, 4'b0000, 1'b1, 4'b0010, 2'd1, 1'b1, 1'b0},
      '{1'b0, 4'b1010, 4'b1010, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b0},
      '{1'b0, 4'b1010, 4'b0000, 1'b1, 4'b1000, 2'd3, 1'b1, 1'b0},
      '{1'b0, 4'b1010, 4'b0000, 1'b1, 4'b1000, 2'd3, 1'b1, 1'b0},
      '{1'b0, 4'b1010, 4'b1010, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b0},
      '{1'b0, 4'b1010, 4'b0000, 1'b1, 4'b0010, 2'd1, 1'b1, 1'b0}
    };
    foreach (v[i]) begin
      rst = v[i].rst; i_req = v[i].req; i_last = v[i].last; i_slave_ack = v[i].ack;
      @(posedge clk); #1;
      n_cmp++;
      if ({o_grant, o_grant_idx, o_busy, o_timeout} !== {v[i].g, v[i].idx, v[i].busy, v[i].to}) begin
        n_fail++;
        $display("FAIL reset_rr[%0d]: grant=%b idx=%0d busy=%b to=%b, expected grant=%b idx=%0d busy=%b to=%b",
                 i, o_grant, o_grant_idx, o_busy, o_timeout, v[i].g, v[i].idx, v[i].busy, v[i].to);
      end
    end
  endtask

  // Sole requester, ack every cycle, never last: 4-beat cap, gap, re-grant.
  task automatic test_max_burst();
    vec_t v [7];
    v = '{
      '{1'b1, 4'b0000, 4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b0},
      '{1'b0, 4'b0001, 4'b0000, 1'b1, 4'b0001, 2'd0, 1'b1, 1'b0},
      '{1'b0, 4'b0001, 4'b0000, 1'b1, 4'b0001, 2'd0, 1'b1, 1'b0},
      '{1'b0, 4'b0001, 4'b0000, 1'b1, 4'b0001, 2'd0, 1'b1, 1'b0},
      '{1'b0, 4'b0001, 4'b0000, 1'b1, 4'b0001, 2'd0, 1'b1, 1'b0},
      '{1'b0, 4'b0001, 4'b0000, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b0},
      '{1'b0, 4'b0001, 4'b0000, 1'b1, 4'b0001, 2'd0, 1'b1, 1'b0}
    };
    foreach (v[i]) begin
      rst = v[i].rst; i_req = v[i].req; i_last = v[i].last; i_slave_ack = v[i].ack;
      @(posedge clk); #1;
      n_cmp++;
      if ({o_grant, o_grant_idx, o_busy, o_timeout} !== {v[i].g, v[i].idx, v[i].busy, v[i].to}) begin
        n_fail++;
        $display("FAIL max_burst[%0d]: grant=%b idx=%0d busy=%b to=%b, expected grant=%b idx=%0d busy=%b to=%b",
                 i, o_grant, o_grant_idx, o_busy, o_timeout, v[i].g, v[i].idx, v[i].busy, v[i].to);
      end
    end
  endtask

  // Master 2 stalls 8 owned cycles: forced release, timeout pulse, search from 3.
  task automatic test_timeout();
    vec_t v [12];
    v[0] = '{1'b1, 4'b0000, 4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b0};
    for (int k = 1; k <= 8; k++)
      v[k] = '{1'b0, 4'b0100, 4'b0000, 1'b0, 4'b0100, 2'd2, 1'b1, 1'b0};
    v[9]  = '{1'b0, 4'b0100, 4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b1};
    v[10] = '{1'b0, 4'b1100, 4'b0000, 1'b0, 4'b1000, 2'd3, 1'b1, 1'b0};
    v[11] = '{1'b0, 4'b1100, 4'b0000, 1'b0, 4'b1000, 2'd3, 1'b1, 1'b0};
    foreach (v[i]) begin
      rst = v[i].rst; i_req = v[i].req; i_last = v[i].last; i_slave_ack = v[i].ack;
      @(posedge clk); #1;
      n_cmp++;
      if ({o_grant, o_grant_idx, o_busy, o_timeout} !== {v[i].g, v[i].idx, v[i].busy, v[i].to}) begin
        n_fail++;
        $display("FAIL timeout[%0d]: grant=%b idx=%0d busy=%b to=%b, expected grant=%b idx=%0d busy=%b to=%b",
                 i, o_grant, o_grant_idx, o_busy, o_timeout, v[i].g, v[i].idx, v[i].busy, v[i].to);
      end
    end
  endtask

  // Ack+last on the cycle that would otherwise time out: normal release, no pulse.
  task automatic test_ack_beats_timeout();
    vec_t v [11];
    v[0] = '{1'b1, 4'b0000, 4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b0};
    for (int k = 1; k <= 8; k++)
      v[k] = '{1'b0, 4'b0010, 4'b0000, 1'b0, 4'b0010, 2'd1, 1'b1, 1'b0};
    v[9]  = '{1'b0, 4'b0010, 4'b0010, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b0};
    v[10] = '{1'b0, 4'b0000, 4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b0};
    foreach (v[i]) begin
      rst = v[i].rst; i_req = v[i].req; i_last = v[i].last; i_slave_ack = v[i].ack;
      @(posedge clk); #1;
      n_cmp++;
      if ({o_grant, o_grant_idx, o_busy, o_timeout} !== {v[i].g, v[i].idx, v[i].busy, v[i].to}) begin
        n_fail++;
        $display("FAIL ack_vs_timeout[%0d]: grant=%b idx=%0d busy=%b to=%b, expected grant=%b idx=%0d busy=%b to=%b",
                 i, o_grant, o_grant_idx, o_busy, o_timeout, v[i].g, v[i].idx, v[i].busy, v[i].to);
      end
    end
  endtask

  // Master 0 withdraws mid-burst while master 3 waits: release, gap, grant 3.
  task automatic test_withdraw();
    vec_t v [5];
    v = '{
      '{1'b1, 4'b0000, 4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b0},
      '{1'b0, 4'b1001, 4'b0000, 1'b1, 4'b0001, 2'd0, 1'b1, 1'b0},
      '{1'b0, 4'b1001, 4'b0000, 1'b1, 4'b0001, 2'd0, 1'b1, 1'b0},
      '{1'b0, 4'b1000, 4'b0000, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b0},
      '{1'b0, 4'b1000, 4'b0000, 1'b1, 4'b1000, 2'd3, 1'b1, 1'b0}
    };
    foreach (v[i]) begin
      rst = v[i].rst; i_req = v[i].req; i_last = v[i].last; i_slave_ack = v[i].ack;
      @(posedge clk); #1;
      n_cmp++;
      if ({o_grant, o_grant_idx, o_busy, o_timeout} !== {v[i].g, v[i].idx, v[i].busy, v[i].to}) begin
        n_fail++;
        $display("FAIL withdraw[%0d]: grant=%b idx=%0d busy=%b to=%b, expected grant=%b idx=%0d busy=%b to=%b",
                 i, o_grant, o_grant_idx, o_busy, o_timeout, v[i].g, v[i].idx, v[i].busy, v[i].to);
      end
    end
  endtask

  // Reset while master 2 owns (beat 3, then beat 1): outputs clear, pointer back to 0.
  task automatic test_reset_mid_burst();
    vec_t v [12];
    v[0] = '{1'b1, 4'b0000, 4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b0};
    for (int k = 1; k <= 4; k++)
      v[k] = '{1'b0, 4'b0100, 4'b0000, 1'b1, 4'b0100, 2'd2, 1'b1, 1'b0};
    v[5]  = '{1'b1, 4'b0100, 4'b0000, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b0};
    v[6]  = '{1'b0, 4'b0101, 4'b0000, 1'b0, 4'b0001, 2'd0, 1'b1, 1'b0};
    v[7]  = '{1'b1, 4'b0000, 4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b0};
    v[8]  = '{1'b0, 4'b0100, 4'b0000, 1'b0, 4'b0100, 2'd2, 1'b1, 1'b0};
    v[9]  = '{1'b0, 4'b0100, 4'b0000, 1'b1, 4'b0100, 2'd2, 1'b1, 1'b0};
    v[10] = '{1'b1, 4'b0100, 4'b0000, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b0};
    v[11] = '{1'b0, 4'b0101, 4'b0000, 1'b0, 4'b0001, 2'd0, 1'b1, 1'b0};
    foreach (v[i]) begin
      rst = v[i].rst; i_req = v[i].req; i_last = v[i].last; i_slave_ack = v[i].ack;
      @(posedge clk); #1;
      n_cmp++;
      if ({o_grant, o_grant_idx, o_busy, o_timeout} !== {v[i].g, v[i].idx, v[i].busy, v[i].to}) begin
        n_fail++;
        $display("FAIL reset_mid[%0d]: grant=%b idx=%0d busy=%b to=%b, expected grant=%b idx=%0d busy=%b to=%b",
                 i, o_grant, o_grant_idx, o_busy, o_timeout, v[i].g, v[i].idx, v[i].busy, v[i].to);
      end
    end
  endtask

  initial begin
    test_reset_rr();
    test_max_burst();
    test_timeout();
    test_ack_beats_timeout();
    test_withdraw();
    test_reset_mid_burst();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
